// File: rtl/two_bit_divider.sv
// rtl/two_bit_divider.sv - radix-4 restoring divider, 32-bit dividend by N-bit divisor
module two_bit_divider #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  a,
  input  logic [N-1:0] b,
  input  logic         vld,
  output logic [31:0]  q,
  output logic [N-1:0] r,
  output logic         result_vld,
  output logic         busy,
  output logic         div_zero
);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

  state_t       state_q;
  logic [31:0]  a_q;
  logic [N-1:0] b_q;
  logic [N-1:0] rem_q;
  logic [3:0]   cnt_q;
  logic [31:0]  q_q;
  logic [N-1:0] r_q;
  logic         result_vld_q;
  logic         busy_q;
  logic         div_zero_q;

  logic [N+1:0] shifted;
  logic [N+1:0] b1;
  logic [N+1:0] b2;
  logic [N+1:0] b3;
  logic [1:0]   digit_d;
  logic [N-1:0] rem_d;
  logic [31:0]  a_d;

  // a_q doubles as the quotient register: dividend bits leave at the top,
  // quotient digits enter at the bottom, so after 16 steps it holds q.
  always_comb begin
    shifted = {rem_q, a_q[31:30]};
    b1      = {2'b00, b_q};
    b2      = {1'b0, b_q, 1'b0};
    b3      = b1 + b2;
    digit_d = 2'd0;
    rem_d   = shifted[N-1:0];
    if (shifted >= b3) begin
      digit_d = 2'd3;
      rem_d   = N'(shifted - b3);
    end else if (shifted >= b2) begin
      digit_d = 2'd2;
      rem_d   = N'(shifted - b2);
    end else if (shifted >= b1) begin
      digit_d = 2'd1;
      rem_d   = N'(shifted - b1);
    end
    a_d = {a_q[29:0], digit_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      q_q          <= '0;
      r_q          <= '0;
      result_vld_q <= 1'b0;
      busy_q       <= 1'b0;
      div_zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (vld) begin
            a_q     <= a;
            b_q     <= b;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (b_q == '0) begin
            q_q          <= '1;
            r_q          <= a_q[N-1:0];
            div_zero_q   <= 1'b1;
            busy_q       <= 1'b0;
            result_vld_q <= 1'b1;
            state_q      <= DONE;
          end else begin
            rem_q      <= '0;
            cnt_q      <= '0;
            div_zero_q <= 1'b0;
            state_q    <= ITER;
          end
        end
        ITER: begin
          a_q   <= a_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            q_q          <= a_d;
            r_q          <= rem_d;
            busy_q       <= 1'b0;
            result_vld_q <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          if (!vld) begin
            result_vld_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign q          = q_q;
  assign r          = r_q;
  assign result_vld = result_vld_q;
  assign busy       = busy_q;
  assign div_zero   = div_zero_q;

endmodule

// File: tb/tb_two_bit_divider.sv
// tb/tb_two_bit_divider.sv - self-checking bench for two_bit_divider
module tb_two_bit_divider;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  a = '0;
  logic [N-1:0] b = '0;
  logic         vld = 1'b0;
  logic [31:0]  q;
  logic [N-1:0] r;
  logic         result_vld;
  logic         busy;
  logic         div_zero;

  int n_vec = 0;
  int n_err = 0;

  two_bit_divider #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .vld(vld),
    .q(q), .r(r), .result_vld(result_vld), .busy(busy), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an operation is a countdown of edges until DONE, result by plain / and %.
  int           m_phase = 0;
  int           m_left = 0;
  logic [31:0]  m_a = '0;
  logic [N-1:0] m_b = '0;
  logic [31:0]  m_q = '0;
  logic [N-1:0] m_r = '0;
  logic         m_dz = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_left = 0; m_q = '0; m_r = '0; m_dz = 1'b0;
    end else begin
      case (m_phase)
        0: if (vld) begin
          m_a = a; m_b = b; m_phase = 1;
          m_left = (b == '0) ? 1 : 17;
        end
        1: begin
          m_left--;
          if (m_b != '0 && m_left == 16) m_dz = 1'b0;
          if (m_left == 0) begin
            m_phase = 2;
            if (m_b == '0) begin
              m_q = '1; m_r = m_a[N-1:0]; m_dz = 1'b1;
            end else begin
              m_q = m_a / 32'(m_b);
              m_r = N'(m_a % 32'(m_b));
            end
          end
        end
        default: if (!vld) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("q", q, m_q);
    chk("r", 32'(r), 32'(m_r));
    chk("result_vld", 32'(result_vld), 32'(m_phase == 2));
    chk("busy", 32'(busy), 32'(m_phase == 1));
    chk("div_zero", 32'(div_zero), 32'(m_dz));
  end

  task automatic do_op(input logic [31:0] ta, input logic [N-1:0] tb_, input logic [31:0] eq,
                       input logic [N-1:0] er, input logic edz, input int lat, input int hold);
    int j;
    int nb;
    @(negedge clk);
    a = ta; b = tb_; vld = 1'b1;
    j = 0; nb = 0;
    do begin
      @(negedge clk);
      j++;
      if (busy) nb++;
    end while (!result_vld && j < 40);
    chk("latency", 32'(j), 32'(lat));
    chk("busy_cycles", 32'(nb), 32'(lat - 1));
    chk("q_lit", q, eq);
    chk("r_lit", 32'(r), 32'(er));
    chk("dz_lit", 32'(div_zero), 32'(edz));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("held_done", 32'({result_vld, busy}), 32'b10);
    end
    vld = 1'b0;
    @(negedge clk);
    chk("rv_drop", 32'(result_vld), 0);
  endtask

  task automatic run_plain(input logic [31:0] ta, input logic [N-1:0] tb_);
    int j;
    @(negedge clk);
    a = ta; b = tb_; vld = 1'b1;
    j = 0;
    do begin
      @(negedge clk);
      j++;
    end while (!result_vld && j < 40);
    chk("sweep_done", 32'(result_vld), 1);
    chk("identity", q * 32'(r == r ? tb_ : tb_) + 32'(r), ta);
    chk("r_lt_b", 32'(r < tb_), 1);
    vld = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int j;
    repeat (3) @(negedge clk);
    chk("rst_q", q, 0);
    chk("rst_r", 32'(r), 0);
    chk("rst_flags", 32'({result_vld, busy, div_zero}), 0);
    rst_n = 1'b1;

    do_op(32'd100, 4'd7, 32'd14, 4'd2, 1'b0, 18, 3);
    do_op(32'hFFFF_FFFF, 4'd15, 32'h1111_1111, 4'd0, 1'b0, 18, 0);
    do_op(32'd3, 4'd9, 32'd0, 4'd3, 1'b0, 18, 0);
    do_op(32'd0, 4'd1, 32'd0, 4'd0, 1'b0, 18, 0);
    do_op(32'd5, 4'd0, 32'hFFFF_FFFF, 4'd5, 1'b1, 2, 0);

    @(negedge clk);
    a = 32'd1000; b = 4'd3; vld = 1'b1;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_q", q, 0);
    chk("abort_flags", 32'({result_vld, busy, div_zero, r}), 0);
    vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(32'd1000, 4'd3, 32'd333, 4'd1, 1'b0, 18, 0);

    @(negedge clk);
    a = 32'd50; b = 4'd6; vld = 1'b1;
    repeat (5) @(negedge clk);
    vld = 1'b0; a = 32'd77; b = 4'd4;
    j = 0;
    do begin
      @(negedge clk);
      j++;
    end while (!result_vld && j < 40);
    chk("drop_rv", 32'(result_vld), 1);
    chk("drop_q", q, 32'd8);
    chk("drop_r", 32'(r), 32'd2);
    @(negedge clk);
    chk("drop_pulse", 32'(result_vld), 0);

    for (int ai = 0; ai < 64; ai++)
      for (int bi = 1; bi < 16; bi++)
        run_plain(32'(ai), N'(bi));

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) vld = ~vld;
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      b = N'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #1 chk("rand_rst", 32'({result_vld, busy, div_zero}), 0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
